instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Small circular buffer used for the instruction FIFO and the in-flight PC queue.
// Latency: a push is visible at the head one cycle later; clr empties it in one cycle.
// Backpressure: none internally, the owner must not push when full or pop when empty.
module ifu_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     clr,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_rdy,
    output logic [WIDTH-1:0]         head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_vld) begin
                mem_d[wr_ptr_q] = push_dat;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_rdy) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push_vld) - (AW+1)'(pop_rdy);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

// Fetch stage: issues word-aligned PC reads, pairs in-order responses with their PC, feeds decode.
// Latency: a response shows on o_instr* the cycle after it arrives; a redirect empties the output next cycle.
// Backpressure: requests held while outstanding + buffered reaches FIFO_DEPTH; responses are never stalled.
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic                  o_imem_req_valid,
    input  logic                  i_imem_req_ready,
    output logic [DATA_WIDTH-1:0] o_imem_req_addr,
    input  logic                  i_imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] i_imem_rsp_data,
    output logic                  o_instr_valid,
    input  logic                  i_instr_ready,
    output logic [DATA_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0] o_instr_pc,
    input  logic                  i_redirect_valid,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_FLUSH} state_e;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
    logic [CW-1:0]           outstanding_q, outstanding_d;
    logic [CW-1:0]           drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]           fifo_count, pcq_count, rsp_dec;
    logic [DATA_WIDTH-1:0]   pcq_head;
    logic [2*DATA_WIDTH-1:0] fifo_head;
    logic                    req_fire, rsp_keep, instr_pop;
    logic                    unused_redirect_lsb;

    assign unused_redirect_lsb = ^i_redirect_pc[1:0];

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        outstanding_d    = outstanding_q;
        drop_cnt_d       = drop_cnt_q;
        o_imem_req_valid = 1'b0;
        rsp_keep         = 1'b0;
        rsp_dec          = CW'(i_imem_rsp_valid);

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                o_imem_req_valid = (({1'b0, outstanding_q} + {1'b0, fifo_count}) < (CW+1)'(FIFO_DEPTH))
                                   && !i_redirect_valid;
                rsp_keep         = i_imem_rsp_valid && (pcq_count != '0);
            end
            S_FLUSH: begin
                // Every response here belongs to a request issued before the redirect.
                if (i_imem_rsp_valid) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                    if (drop_cnt_q == CW'(1)) begin
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_fire      = o_imem_req_valid && i_imem_req_ready;
        outstanding_d = outstanding_q + CW'(req_fire) - rsp_dec;
        if (req_fire) begin
            pc_d = pc_q + DATA_WIDTH'(4);
        end

        // A redirect overrides whatever the state logic decided this cycle.
        if (i_redirect_valid) begin
            pc_d          = {i_redirect_pc[DATA_WIDTH-1:2], 2'b00};
            drop_cnt_d    = outstanding_q - rsp_dec;
            outstanding_d = outstanding_q - rsp_dec;
            rsp_keep      = 1'b0;
            state_d       = (drop_cnt_d != '0) ? S_FLUSH : S_FETCH;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign instr_pop       = o_instr_valid && i_instr_ready && !i_redirect_valid;
    assign o_instr_valid   = (fifo_count != '0);
    assign o_imem_req_addr = pc_q;
    assign {o_instr_pc, o_instr} = fifo_head;

    ifu_fifo #(.WIDTH(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clr      (i_redirect_valid),
        .push_vld (rsp_keep),
        .push_dat ({pcq_head, i_imem_rsp_data}),
        .pop_rdy  (instr_pop),
        .head_dat (fifo_head),
        .count    (fifo_count)
    );

    ifu_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_pc_queue (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .clr      (i_redirect_valid),
        .push_vld (req_fire),
        .push_dat (pc_q),
        .pop_rdy  (rsp_keep),
        .head_dat (pcq_head),
        .count    (pcq_count)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory with variable latency, queue-based reference model, directed and random phases.
module tb_instr_fetch_unit;
    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic        i_instr_ready;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;

    always #5 i_clk = ~i_clk;

    instr_fetch_unit #(.DATA_WIDTH(DW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .i_instr_ready    (i_instr_ready),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_redirect_valid (i_redirect_valid),
        .i_redirect_pc    (i_redirect_pc)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
    endfunction

    // Memory: accepts at the end of a cycle, answers in order after lat cycles, one word per cycle.
    int          cyc      = 0;
    int          lat      = 1;
    bit          rand_lat = 1'b0;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] acc_log[$];
    logic [31:0] junk_a;
    int          junk_d;

    initial begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        forever begin
            @(negedge i_clk);
            cyc++;
            if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = word(mq_addr[0]);
            end else begin
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = $urandom;
            end
            #4;
            if (i_reset) begin
                mq_addr.delete();
                mq_due.delete();
            end else begin
                if (i_imem_rsp_valid) begin
                    junk_a = mq_addr.pop_front();
                    junk_d = mq_due.pop_front();
                end
                if (o_imem_req_valid && i_imem_req_ready) begin
                    mq_addr.push_back(o_imem_req_addr);
                    mq_due.push_back(cyc + (rand_lat ? 1 + int'($urandom % 4) : lat));
                    acc_log.push_back(o_imem_req_addr);
                end
            end
        end
    end

    // Reference model: PC, queue of in-flight PCs, count of responses to discard, buffered entries.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } ent_t;

    ent_t        m_fifo[$];
    logic [31:0] m_pend[$];
    logic [31:0] m_pc   = RPC;
    int          m_drop = 0;
    bit          m_idle = 1'b1;
    bit          exp_req;
    bit          got;
    ent_t        e;

    initial begin
        forever begin
            @(negedge i_clk);
            #3;
            if (i_reset) begin
                chkb("rst_req_vld",   o_imem_req_valid, 1'b0);
                chk ("rst_req_addr",  o_imem_req_addr,  RPC);
                chkb("rst_instr_vld", o_instr_valid,    1'b0);
                m_fifo.delete();
                m_pend.delete();
                m_pc   = RPC;
                m_drop = 0;
                m_idle = 1'b1;
            end else begin
                exp_req = !m_idle && (m_drop == 0) && (m_pend.size() + m_fifo.size() < DEPTH)
                          && !i_redirect_valid;
                chkb("req_vld",   o_imem_req_valid, exp_req);
                chk ("req_addr",  o_imem_req_addr,  m_pc);
                chkb("instr_vld", o_instr_valid,    m_fifo.size() > 0);
                if (m_fifo.size() > 0) begin
                    chk("instr",    o_instr,    m_fifo[0].dat);
                    chk("instr_pc", o_instr_pc, m_fifo[0].pc);
                end
                if (i_redirect_valid) begin
                    m_drop = m_pend.size() + m_drop - (i_imem_rsp_valid ? 1 : 0);
                    m_pend.delete();
                    m_fifo.delete();
                    m_pc = {i_redirect_pc[31:2], 2'b00};
                end else begin
                    got = 1'b0;
                    if (i_imem_rsp_valid) begin
                        if (m_drop > 0) begin
                            m_drop--;
                        end else if (m_pend.size() > 0) begin
                            e.pc  = m_pend.pop_front();
                            e.dat = i_imem_rsp_data;
                            got   = 1'b1;
                        end else begin
                            failures++;
                            $display("FAIL unexpected_rsp: response with nothing outstanding at %0t", $time);
                        end
                    end
                    if (m_fifo.size() > 0 && i_instr_ready) begin
                        e.pc = e.pc;
                        m_fifo.pop_front();
                    end
                    if (got) m_fifo.push_back(e);
                    if (exp_req && i_imem_req_ready) begin
                        m_pend.push_back(m_pc);
                        m_pc = m_pc + 32'd4;
                    end
                end
                m_idle = 1'b0;
            end
        end
    end

    task automatic nxt();
        @(negedge i_clk);
        #2;
    endtask

    // Leaves the bench at +2 of the first cycle after release (the idle cycle).
    task automatic do_reset();
        @(negedge i_clk);
        #1;
        i_reset          = 1'b1;
        i_redirect_valid = 1'b0;
        repeat (2) @(negedge i_clk);
        acc_log.delete();
        i_reset = 1'b0;
        #2;
    endtask

    initial begin
        i_reset          = 1'b1;
        i_imem_req_ready = 1'b1;
        i_instr_ready    = 1'b1;
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;

        // Streaming with single-cycle memory.
        lat = 1;
        do_reset();
        chkb("t1_idle_req", o_imem_req_valid, 1'b0);
        nxt();
        chkb("t1_req0_vld",  o_imem_req_valid, 1'b1);
        chk ("t1_req0_addr", o_imem_req_addr,  32'h0);
        nxt();
        chkb("t1_instr_not_yet", o_instr_valid, 1'b0);
        nxt();
        chkb("t1_instr0_vld", o_instr_valid, 1'b1);
        chk ("t1_instr0_pc",  o_instr_pc,    32'h0);
        chk ("t1_instr0",     o_instr,       32'h5a5a_f0f0);
        nxt();
        chk ("t1_instr1_pc",  o_instr_pc,    32'h4);
        chk ("t1_instr1",     o_instr,       32'h5a5e_f0f4);
        repeat (9) nxt();
        chkb("t1_enough_issued", acc_log.size() >= 4, 1'b1);
        if (acc_log.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("t1_issue_order", acc_log[i], 32'(4 * i));
        end

        // Decode stalled: the buffer fills and issue stops at two.
        i_instr_ready = 1'b0;
        do_reset();
        repeat (8) nxt();
        chk ("t2_issued",    32'(acc_log.size()), 32'd2);
        chkb("t2_req_held",  o_imem_req_valid,    1'b0);
        chkb("t2_full_vld",  o_instr_valid,       1'b1);
        chk ("t2_head_pc",   o_instr_pc,          32'h0);
        i_instr_ready = 1'b1;
        nxt();
        chk ("t2_head_pc2",  o_instr_pc,          32'h4);
        chkb("t2_resume",    o_imem_req_valid,    1'b1);
        chk ("t2_resume_ad", o_imem_req_addr,     32'h8);

        // Memory not ready: request held stable.
        i_imem_req_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            nxt();
            chkb("t3_hold_vld",  o_imem_req_valid, 1'b1);
            chk ("t3_hold_addr", o_imem_req_addr,  32'h0);
        end
        i_imem_req_ready = 1'b1;
        nxt();
        chkb("t3_next_vld",  o_imem_req_valid, 1'b1);
        chk ("t3_next_addr", o_imem_req_addr,  32'h4);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        do_reset();
        nxt();
        nxt();
        nxt();
        chkb("t4_credit_block", o_imem_req_valid, 1'b0);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h103;
        @(negedge i_clk);
        i_redirect_valid = 1'b0;
        #2;
        chk ("t4_new_pc",    o_imem_req_addr,  32'h100);
        chkb("t4_flush_req", o_imem_req_valid, 1'b0);
        chkb("t4_flush_out", o_instr_valid,    1'b0);
        nxt();
        chkb("t4_flush_req2", o_imem_req_valid, 1'b0);
        chkb("t4_flush_out2", o_instr_valid,    1'b0);
        nxt();
        chkb("t4_fetch_vld",  o_imem_req_valid, 1'b1);
        chk ("t4_fetch_addr", o_imem_req_addr,  32'h100);
        for (int n = 0; n < 20 && !o_instr_valid; n++) nxt();
        chkb("t4_instr_seen", o_instr_valid, 1'b1);
        chk ("t4_first_pc",   o_instr_pc,    32'h100);
        chk ("t4_first_word", o_instr,       32'h5b5a_f1f0);

        // Redirect together with a response and a decode pop.
        lat = 1;
        do_reset();
        for (int n = 0; n < 20 && !(o_instr_valid && i_imem_rsp_valid); n++) nxt();
        chkb("t5_found", o_instr_valid && i_imem_rsp_valid, 1'b1);
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h2000;
        @(negedge i_clk);
        i_redirect_valid = 1'b0;
        #2;
        chkb("t5_fifo_empty", o_instr_valid,    1'b0);
        chkb("t5_no_flush",   o_imem_req_valid, 1'b1);
        chk ("t5_addr",       o_imem_req_addr,  32'h2000);

        // Asynchronous reset with a full buffer.
        i_instr_ready = 1'b0;
        do_reset();
        repeat (6) nxt();
        chkb("t6_full", o_instr_valid, 1'b1);
        @(negedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        chkb("t6_async_vld",   o_instr_valid,    1'b0);
        chk ("t6_async_instr", o_instr,          32'h0);
        chk ("t6_async_pc",    o_instr_pc,       32'h0);
        chkb("t6_async_req",   o_imem_req_valid, 1'b0);
        chk ("t6_async_addr",  o_imem_req_addr,  RPC);
        repeat (2) @(negedge i_clk);
        acc_log.delete();
        i_reset       = 1'b0;
        i_instr_ready = 1'b1;
        #2;
        chkb("t6_idle", o_imem_req_valid, 1'b0);
        nxt();
        chkb("t6_first_vld",  o_imem_req_valid, 1'b1);
        chk ("t6_first_addr", o_imem_req_addr,  RPC);

        // Random traffic against the model.
        rand_lat = 1'b1;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            nxt();
            i_imem_req_ready = ($urandom % 4) != 0;
            i_instr_ready    = ($urandom % 3) != 0;
            if (i_redirect_valid) i_redirect_valid = 1'b0;
            else                  i_redirect_valid = ($urandom % 20) == 0;
            i_redirect_pc = $urandom;
            if (($urandom % 700) == 0) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
